// File: rtl/clk_div.sv
// -----------------------------------------------------------------------------
// clk_div
//
// Programmable integer clock divider. It divides CLK by a run-time ratio N
// and drives the result on DIV_CLK. For N >= 2 each period is
// ceil(N/2) cycles low followed by floor(N/2) cycles high. While disabled,
// or when given a ratio of 0 or 1, the block sits in IDLE and passes CLK
// straight through. The ratio and the enable are only sampled in IDLE and
// on the last HIGH cycle, so a running period is never truncated or
// stretched.
//
// The IDLE <-> divide output switch is not glitch-free. Consumers of
// DIV_CLK must be held in reset, or must ignore DIV_CLK, across the switch.
//
// Ports:
//   CLK        in   1         reference clock; all flops are rising-edge
//   RST        in   1         asynchronous reset, active-high
//   CLK_EN     in   1         divider enable, synchronous to CLK
//   DIV_RATIO  in   RATIO_WD  division ratio N (0 or 1 selects bypass)
//   DIV_CLK    out  1         divided clock; equals CLK while in bypass
// -----------------------------------------------------------------------------
module clk_div #(
    parameter int RATIO_WD = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLK_EN,
    input  logic [RATIO_WD-1:0] DIV_RATIO,
    output logic                DIV_CLK
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                div_q,   div_d;
    logic [RATIO_WD-1:0] cnt_q,   cnt_d;
    logic [RATIO_WD-1:0] ratio_q, ratio_d;

    logic [RATIO_WD-1:0] low_last;
    logic [RATIO_WD-1:0] high_last;
    logic                start_ok;

    // Last count of each phase, derived from the latched ratio only.
    // L-1 = ceil(N/2)-1 = (N-1)>>1, and H-1 = (N>>1)-1. Written this way
    // neither expression needs an extra bit for N = 2^RATIO_WD-1, and
    // neither underflows because ratio_q >= 2 outside IDLE.
    assign low_last  = (ratio_q - RATIO_WD'(1)) >> 1;
    assign high_last = (ratio_q >> 1) - RATIO_WD'(1);

    // A new period may start only with the enable set and a real ratio.
    assign start_ok  = CLK_EN && (DIV_RATIO >= RATIO_WD'(2));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;

        case (state_q)
            ST_IDLE: begin
                div_d = 1'b0;
                cnt_d = '0;
                if (start_ok) begin
                    ratio_d = DIV_RATIO;
                    state_d = ST_LOW;
                end
            end

            ST_LOW: begin
                if (cnt_q == low_last) begin
                    cnt_d   = '0;
                    div_d   = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + RATIO_WD'(1);
                end
            end

            ST_HIGH: begin
                if (cnt_q == high_last) begin
                    // Period boundary: the only point, besides IDLE, where a
                    // new ratio or a dropped enable is allowed to take effect.
                    cnt_d = '0;
                    div_d = 1'b0;
                    if (start_ok) begin
                        ratio_d = DIV_RATIO;
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + RATIO_WD'(1);
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean bypass.
                div_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: all state is reset asynchronously so the output returns to
    // bypass the moment RST rises, without waiting for a CLK edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            div_q   <= 1'b0;
            cnt_q   <= '0;
            ratio_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
        end
    end

    // Bypass passes the reference clock through; otherwise the output is the
    // div_q flop, so divided edges align with CLK rising edge plus clk-to-q.
    assign DIV_CLK = (state_q == ST_IDLE) ? CLK : div_q;

endmodule

// File: tb/tb_clk_div.sv
// -----------------------------------------------------------------------------
// tb_clk_div
//
// Directed self-checking bench for clk_div. Expected DIV_CLK values come from
// the phase formula: k cycles after the enable edge, DIV_CLK is high when
// (k mod N) >= ceil(N/2), otherwise low. In bypass DIV_CLK must track CLK.
// -----------------------------------------------------------------------------
module tb_clk_div;

    localparam int RATIO_WD = 8;
    localparam logic [1:0] IDLE_ENC = 2'd0;

    logic                clk;
    logic                rst;
    logic                clk_en;
    logic [RATIO_WD-1:0] div_ratio;
    logic                div_clk;

    int tests;
    int fails;

    clk_div #(.RATIO_WD(RATIO_WD)) dut (
        .CLK       (clk),
        .RST       (rst),
        .CLK_EN    (clk_en),
        .DIV_RATIO (div_ratio),
        .DIV_CLK   (div_clk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the divided waveform for samples k0 .. k0+cycles-1 after the
    // enable edge. Entry: sitting at sample k0. Exit: at sample k0+cycles.
    task automatic run_wave(input string tag, input int n, input int k0, input int cycles);
        int l;
        l = (n + 1) / 2;
        for (int k = k0; k < k0 + cycles; k++) begin
            check($sformatf("%s k=%0d", tag, k), 32'(div_clk), 32'(((k % n) >= l) ? 1 : 0));
            tick();
        end
    endtask

    // Bypass: state stays IDLE and DIV_CLK follows CLK on both phases.
    task automatic bypass_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check($sformatf("%s state c%0d", tag, i), 32'(dut.state_q), 32'(IDLE_ENC));
            check($sformatf("%s hi c%0d", tag, i), 32'(div_clk), 32'd1);
            @(negedge clk);
            #1;
            check($sformatf("%s lo c%0d", tag, i), 32'(div_clk), 32'd0);
            tick();
        end
    endtask

    // Pulse reset between edges, apply new inputs, then step past the next
    // edge. With a valid enable that edge is E0 (IDLE -> LOW).
    task automatic restart(input logic en, input logic [RATIO_WD-1:0] n);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        clk_en = en;
        div_ratio = n;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        clk_en = 1'b1;
        div_ratio = 8'd4;

        // Reset with a valid enable applied: bypass, all registers clear.
        tick();
        check("rst state", 32'(dut.state_q), 32'(IDLE_ENC));
        check("rst div_q", 32'(dut.div_q), 32'd0);
        check("rst cnt", 32'(dut.cnt_q), 32'd0);
        check("rst ratio", 32'(dut.ratio_q), 32'd0);
        check("rst clk hi", 32'(div_clk), 32'd1);
        @(negedge clk);
        #1;
        check("rst clk lo", 32'(div_clk), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_wave("n4", 4, 0, 12);

        // Odd ratios: low phase one cycle longer.
        restart(1'b1, 8'd5);
        run_wave("n5", 5, 0, 15);
        restart(1'b1, 8'd3);
        run_wave("n3", 3, 0, 9);

        // Bypass ratios and disabled enable.
        restart(1'b1, 8'd1);
        bypass_check("byp n1", 3);
        restart(1'b1, 8'd0);
        bypass_check("byp n0", 3);
        restart(1'b0, 8'd6);
        bypass_check("byp en0", 3);

        // Ratio change during cycle 2 of LOW: old period finishes, then N=2.
        restart(1'b1, 8'd6);
        run_wave("chg old", 6, 0, 1);
        div_ratio = 8'd2;
        run_wave("chg old", 6, 1, 5);
        run_wave("chg n2", 2, 0, 8);

        // Disable during LOW: the full 4/4 period completes, then bypass.
        restart(1'b1, 8'd8);
        run_wave("dis", 8, 0, 2);
        clk_en = 1'b0;
        run_wave("dis", 8, 2, 6);
        bypass_check("dis byp", 2);

        // Async reset during cycle 2 of HIGH with N=7 (L=4, H=3).
        restart(1'b1, 8'd7);
        run_wave("arst pre", 7, 0, 5);
        #2;
        rst = 1'b1;
        #1;
        check("arst div_q", 32'(dut.div_q), 32'd0);
        check("arst cnt", 32'(dut.cnt_q), 32'd0);
        check("arst ratio", 32'(dut.ratio_q), 32'd0);
        check("arst state", 32'(dut.state_q), 32'(IDLE_ENC));
        check("arst bypass", 32'(div_clk), 32'(clk));
        rst = 1'b0;
        tick();
        run_wave("arst post", 7, 0, 7);

        // Maximum ratio: L=128, H=127; counter must reach 127.
        restart(1'b1, 8'd255);
        run_wave("n255", 255, 0, 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
